transmissor_jogada_serial: RTL and testbench
============================================

// Module: transmissor_jogada_serial
// PURPOSE
//  Downstream of the game datapath. On a request from the control unit it latches the last move
//  (macro addr, micro addr, current player, game result) and sends it as a 4-byte ASCII frame
//  on a UART 8N1 line to the external display/PC. It raises fim_tx once the frame has finished,
//  and the control unit's serial wait interval runs alongside it.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200 baud); legal range >= 2
//  CNT_W         9    width of bit-period counter; must hold CLKS_PER_BIT-1
// PORTS
//  clock         in   1  single system clock, rising edge
//  reset         in   1  asynchronous, active-high; returns block to idle immediately
//  partida       in   1  start request, sampled on rising edge, 1-cycle pulse expected
//  addr_macro    in   4  binary macro cell 0..8
//  addr_micro    in   4  binary micro cell 0..8
//  jogador       in   2  01 = X, 10 = O, other = none
//  resultado     in   2  00 = in progress, 01 = X won, 10 = O won, 11 = draw
//  saida_serial  out  1  UART TX line, idle high
//  ocupado       out  1  high from the cycle after accepted partida until fim_tx
//  fim_tx        out  1  1-cycle pulse after the last stop bit completes
//  db_estado     out  3  current FSM state code, for HEX debug
// BEHAVIOUR
//  Reset values: saida_serial = 1, ocupado = 0, fim_tx = 0, db_estado = INICIAL, counters = 0.
//  Frame bytes, computed from the latched inputs:
//   B0 = 0x30 + addr_macro;  B1 = 0x30 + addr_micro  (an addr of 9..15 sends 0x3F '?').
//   B2 = jogador 01 -> 0x58 'X', 10 -> 0x4F 'O', else 0x2D '-'.
//   B3 = resultado 00 -> 0x0A LF, 01 -> 0x78 'x', 10 -> 0x6F 'o', 11 -> 0x3D '='.
//  Inputs are latched on the accepting edge; changes during transmission do not affect the frame.
//  Each byte is sent as: start bit (0), data LSB first, stop bit (1). Each bit lasts exactly
//   CLKS_PER_BIT cycles.
//  Bytes follow back-to-back with no idle gap. Total frame = 40*CLKS_PER_BIT cycles.
//  FSM states (3-bit code):
//   INICIAL  000 -> CARREGA when partida
//   CARREGA  001 -> START; latches inputs, byte index = 0
//   START    010 -> DADOS after one bit period
//   DADOS    011 -> STOP after 8 bit periods
//   STOP     100 -> PROX when the bit period ends
//   PROX     101 -> START if byte index < 3 (then index++), else FINAL
//   FINAL    110 -> INICIAL; fim_tx = 1 for this cycle
//  CARREGA and PROX take 1 cycle each; that cycle is absorbed into the adjacent bit period, so
//   the on-line bit timing stays exact.
//  Latency: start bit drives the line starting 2 cycles after the partida edge.
//  ocupado = 1 in every state except INICIAL.
//  partida while ocupado: ignored, no queueing.
//  partida in the FINAL cycle: ignored; a new request must be issued at least 1 cycle later.
//  Bit counter wraps at CLKS_PER_BIT-1. Bit index 0..7 and byte index 0..3 are plain
//   counters, cleared in CARREGA.
//  Reset mid-frame: line goes high asynchronously, the partial frame is discarded, and no
//   fim_tx pulse is generated.
// STRUCTURE
//  Include file serial_defs.vh holds:
//   - the ASCII constants (0x30 base, 'X', 'O', '-', LF, 'x', 'o', '=', '?');
//   - the state encodings;
//   - the CLKS_PER_BIT default.
//  Byte formatting (4:1 mux plus ASCII mapping) is combinational in this module.
//  The bit-period timer reuses contador_m #(CLKS_PER_BIT, CNT_W), with fim used as the bit tick.
//  No further sub-module.
// TESTING (CLKS_PER_BIT = 4 in bench)
//  1. After reset, idle 20 cycles -> saida_serial = 1, ocupado = 0, fim_tx never high.
//  2. partida with macro = 4, micro = 7, jogador = 01, resultado = 00 -> UART monitor decodes
//     0x34 0x37 0x58 0x0A; fim_tx pulses exactly 2 + 160 cycles after the partida edge.
//  3. macro = 9, micro = 0, jogador = 00, resultado = 11 -> 0x3F 0x30 0x2D 0x3D.
//  4. Second partida pulse 30 cycles into a frame -> ignored; exactly 4 bytes, a single
//     fim_tx pulse.
//  5. Inputs changed mid-frame (jogador 01 -> 10) -> B2 stays 0x58.
//  6. reset asserted at cycle 50 of a frame -> line high in the same cycle; the next partida
//     produces a clean full frame.

Source files
------------

// File: rtl/transmissor_jogada_serial_pkg.sv
// rtl/transmissor_jogada_serial_pkg.sv - shared constants, state codes and ASCII mapping for the move transmitter
package transmissor_jogada_serial_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_X_LOW = 8'h78;
  localparam logic [7:0] ASCII_O_LOW = 8'h6F;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    INICIAL = 3'b000,
    CARREGA = 3'b001,
    START   = 3'b010,
    DADOS   = 3'b011,
    STOP    = 3'b100,
    PROX    = 3'b101,
    FINAL   = 3'b110
  } estado_t;

  // Cell addresses only go up to 8; anything larger is shown as '?'.
  function automatic logic [7:0] ascii_digito(input logic [3:0] addr);
    if (addr > 4'd8) return ASCII_QMARK;
    return ASCII_ZERO + {4'd0, addr};
  endfunction

  function automatic logic [7:0] ascii_jogador(input logic [1:0] jog);
    case (jog)
      2'b01:   return ASCII_X;
      2'b10:   return ASCII_O;
      default: return ASCII_DASH;
    endcase
  endfunction

  function automatic logic [7:0] ascii_resultado(input logic [1:0] res);
    case (res)
      2'b00:   return ASCII_LF;
      2'b01:   return ASCII_X_LOW;
      2'b10:   return ASCII_O_LOW;
      default: return ASCII_EQ;
    endcase
  endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M counter with clear, enable and terminal-count flag
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  // Count up while enabled, wrapping to zero after M-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      if (q == ULTIMO) q <= '0;
      else             q <= q + N'(1);
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/transmissor_jogada_serial.sv
// rtl/transmissor_jogada_serial.sv - sends the last move as a 4-byte ASCII frame on a UART 8N1 line
module transmissor_jogada_serial
  import transmissor_jogada_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [3:0] addr_macro,
  input  logic [3:0] addr_micro,
  input  logic [1:0] jogador,
  input  logic [1:0] resultado,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       fim_tx,
  output logic [2:0] db_estado
);

  // STOP ends one cycle early; the PROX cycle completes the stop bit so bytes stay back-to-back.
  localparam logic [CNT_W-1:0] STOP_ULTIMO = CNT_W'(CLKS_PER_BIT - 2);

  estado_t          estado, prox_estado;
  logic [3:0]       macro_q, micro_q;
  logic [1:0]       jog_q, res_q;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       byte_atual;
  logic [CNT_W-1:0] cnt_q;
  logic             bit_fim, zera, conta, linha_d;

  contador_m #(.M(CLKS_PER_BIT), .N(CNT_W)) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .q     (cnt_q),
    .fim   (bit_fim)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox_estado;
  end

  // Next state, timer control and the unregistered line level.
  always_comb begin
    prox_estado = estado;
    zera        = 1'b0;
    conta       = 1'b0;
    linha_d     = 1'b1;
    case (estado)
      INICIAL: begin
        zera = 1'b1;
        if (partida) prox_estado = CARREGA;
      end
      CARREGA: begin
        zera        = 1'b1;
        prox_estado = START;
      end
      START: begin
        conta   = 1'b1;
        linha_d = 1'b0;
        if (bit_fim) prox_estado = DADOS;
      end
      DADOS: begin
        conta   = 1'b1;
        linha_d = byte_atual[bit_idx];
        if (bit_fim && bit_idx == 3'd7) prox_estado = STOP;
      end
      STOP: begin
        conta = 1'b1;
        if (cnt_q == STOP_ULTIMO) prox_estado = PROX;
      end
      PROX: begin
        conta       = 1'b1;
        prox_estado = (byte_idx == 2'd3) ? FINAL : START;
      end
      FINAL:   prox_estado = INICIAL;
      default: prox_estado = INICIAL;
    endcase
  end

  // Latch the move on the accepting edge and step the bit/byte indices.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      macro_q  <= '0;
      micro_q  <= '0;
      jog_q    <= '0;
      res_q    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if (estado == INICIAL && partida) begin
        macro_q <= addr_macro;
        micro_q <= addr_micro;
        jog_q   <= jogador;
        res_q   <= resultado;
      end
      if (estado == CARREGA) begin
        bit_idx  <= '0;
        byte_idx <= '0;
      end else begin
        if (estado == DADOS && bit_fim)         bit_idx  <= bit_idx + 3'd1;
        if (estado == PROX && byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Select and format the byte currently on the line.
  always_comb begin
    byte_atual = ASCII_QMARK;
    case (byte_idx)
      2'd0:    byte_atual = ascii_digito(macro_q);
      2'd1:    byte_atual = ascii_digito(micro_q);
      2'd2:    byte_atual = ascii_jogador(jog_q);
      default: byte_atual = ascii_resultado(res_q);
    endcase
  end

  // Registered line and done pulse; reset forces the line idle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_serial <= 1'b1;
      fim_tx       <= 1'b0;
    end else begin
      saida_serial <= linha_d;
      fim_tx       <= (estado == FINAL);
    end
  end

  assign ocupado   = (estado != INICIAL);
  assign db_estado = estado;

endmodule

// File: tb/tb_transmissor_jogada_serial.sv
// tb/tb_transmissor_jogada_serial.sv - scoreboard bench for the serial move transmitter
module tb_transmissor_jogada_serial;

  localparam int CPB   = 4;
  localparam int CW    = 2;
  localparam int FRAME = 40 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida = 1'b0;
  logic [3:0] addr_macro = '0;
  logic [3:0] addr_micro = '0;
  logic [1:0] jogador = '0;
  logic [1:0] resultado = '0;
  logic       saida_serial, ocupado, fim_tx;
  logic [2:0] db_estado;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [7:0] exp_bytes[$];
  int         exp_fim[$];

  transmissor_jogada_serial #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .addr_macro   (addr_macro),
    .addr_micro   (addr_micro),
    .jogador      (jogador),
    .resultado    (resultado),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .fim_tx       (fim_tx),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nome, input int atual, input int esperado);
    checks++;
    if (atual == esperado) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nome, atual, esperado, cyc);
  endtask

  // Issue a one-cycle partida and queue the expected bytes and done-pulse cycle.
  task automatic send(input logic [3:0] m, input logic [3:0] u, input logic [1:0] j,
                      input logic [1:0] r, input logic [31:0] bytes, input int nbytes,
                      input bit espera_fim);
    @(negedge clock);
    addr_macro = m;
    addr_micro = u;
    jogador    = j;
    resultado  = r;
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(bytes[31-8*i -: 8]);
    if (espera_fim) exp_fim.push_back(cyc + 1 + 2 + FRAME);
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && ocupado; i++) @(negedge clock);
    check("frame_ends", ocupado, 0);
    repeat (5) @(negedge clock);
  endtask

  // Done-pulse monitor: every pulse must match a queued expectation in time.
  always @(negedge clock) begin
    if (fim_tx) begin
      if (exp_fim.size() == 0) begin
        checks++;
        $display("FAIL fim_tx_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("fim_tx_cycle", cyc, exp_fim.pop_front());
      end
    end
  end

  // UART monitor: decode 8N1 bytes from the line, abandoning a byte if reset hits.
  initial begin : uart_rx
    logic [7:0] dado;
    logic       bit_start, bit_stop;
    bit         abortado;
    dado = '0;
    bit_start = 1'b0;
    bit_stop = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && saida_serial == 1'b0) begin
        abortado = 1'b0;
        for (int w = 0; w < CPB / 2; w++) begin
          @(negedge clock);
          if (reset) abortado = 1'b1;
        end
        for (int k = 0; k < 10 && !abortado; k++) begin
          if (k > 0) begin
            for (int w = 0; w < CPB; w++) begin
              @(negedge clock);
              if (reset) abortado = 1'b1;
            end
          end
          if (!abortado) begin
            if (k == 0)     bit_start = saida_serial;
            else if (k < 9) dado[k-1] = saida_serial;
            else            bit_stop  = saida_serial;
          end
        end
        if (!abortado) begin
          check("start_bit", bit_start, 0);
          check("stop_bit", bit_stop, 1);
          if (exp_bytes.size() == 0) begin
            checks++;
            $display("FAIL byte_unexpected: got 0x%02h expected none", dado);
          end else begin
            check("byte", dado, exp_bytes.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int nao_idle;
    repeat (3) @(negedge clock);
    check("reset_line", saida_serial, 1);
    check("reset_ocupado", ocupado, 0);
    check("reset_fim_tx", fim_tx, 0);
    check("reset_estado", db_estado, 0);
    reset = 1'b0;

    // 1: idle after reset
    nao_idle = 0;
    repeat (20) begin
      @(negedge clock);
      if (saida_serial !== 1'b1 || ocupado !== 1'b0) nao_idle++;
    end
    check("idle_20", nao_idle, 0);

    // 2: basic frame with latency check
    send(4'd4, 4'd7, 2'b01, 2'b00, 32'h3437580A, 4, 1'b1);
    check("ocupado_after_accept", ocupado, 1);
    @(negedge clock);
    check("latency_line_still_high", saida_serial, 1);
    @(negedge clock);
    check("latency_start_bit", saida_serial, 0);
    check("estado_start", db_estado, 3'b010);
    wait_idle();

    // 3: out-of-range address, no player, draw
    send(4'd9, 4'd0, 2'b00, 2'b11, 32'h3F302D3D, 4, 1'b1);
    wait_idle();

    // 4: second partida mid-frame is ignored
    send(4'd0, 4'd8, 2'b10, 2'b10, 32'h30384F6F, 4, 1'b1);
    repeat (29) @(negedge clock);
    addr_macro = 4'd1;
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    wait_idle();

    // 5: inputs changed mid-frame do not alter the frame
    send(4'd2, 4'd3, 2'b01, 2'b01, 32'h32335878, 4, 1'b1);
    repeat (59) @(negedge clock);
    jogador    = 2'b10;
    addr_macro = 4'd5;
    resultado  = 2'b11;
    wait_idle();

    // 6: reset at cycle 50 of a frame; only the first byte completes
    send(4'd1, 4'd8, 2'b10, 2'b01, 32'h31000000, 1, 1'b0);
    repeat (49) @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_mid_line", saida_serial, 1);
    check("reset_mid_ocupado", ocupado, 0);
    check("reset_mid_estado", db_estado, 0);
    repeat (6) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send(4'd1, 4'd8, 2'b10, 2'b01, 32'h31384F78, 4, 1'b1);
    wait_idle();

    repeat (10) @(negedge clock);
    check("bytes_left", exp_bytes.size(), 0);
    check("fim_left", exp_fim.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
